// File: rtl/fetch_unit.sv
// Instruction fetch stage: single outstanding imem request, one registered
// output slot plus a one-entry skid buffer, with branch redirect and drop.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc_out,
  output logic [6:0]  Op,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7
);

  typedef enum logic [1:0] {IDLE, REQ, FULL, DROP} state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] hold_addr, hold_n;
  entry_t      out_q, out_n;
  entry_t      skid, skid_n;
  logic        vld_q, vld_n;
  logic        consumed, blocked;

  assign consumed = vld_q & ~stall;
  assign blocked  = vld_q & stall;

  assign imem_req    = (state == REQ) || (state == DROP);
  // The PC already points at the redirect target while the abandoned request
  // is still outstanding, so DROP keeps presenting the original address.
  assign imem_addr   = (state == DROP) ? hold_addr : pc;
  assign instr_valid = vld_q;
  assign instr       = out_q.instr;
  assign pc_out      = out_q.pc;
  assign Op          = out_q.instr[6:0];
  assign funct3      = out_q.instr[14:12];
  assign funct7      = out_q.instr[31:25];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= RESET_PC;
      hold_addr <= RESET_PC;
      out_q     <= {NOP_INSTR, RESET_PC};
      vld_q     <= 1'b0;
      skid      <= '0;
    end else begin
      pc        <= pc_n;
      hold_addr <= hold_n;
      out_q     <= out_n;
      vld_q     <= vld_n;
      skid      <= skid_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    hold_n  = hold_addr;
    out_n   = out_q;
    vld_n   = vld_q;
    skid_n  = skid;
    if (branch_taken) begin
      pc_n        = branch_target & 32'hFFFF_FFFC;
      vld_n       = 1'b0;
      out_n.instr = NOP_INSTR;
      skid_n      = '0;
      case (state)
        REQ: begin
          if (imem_ready) state_n = REQ;
          else begin
            state_n = DROP;
            hold_n  = pc;
          end
        end
        DROP:    state_n = imem_ready ? REQ : DROP;
        default: state_n = REQ;
      endcase
    end else begin
      // A consumed slot empties unless this cycle refills it below.
      if (consumed) begin
        vld_n       = 1'b0;
        out_n.instr = NOP_INSTR;
      end
      case (state)
        IDLE: if (!blocked) state_n = REQ;
        REQ: begin
          if (imem_ready) begin
            pc_n = pc + 32'd4;
            if (!blocked) begin
              out_n   = {imem_rdata, pc};
              vld_n   = 1'b1;
              // A held stall would block the slot we just filled.
              state_n = stall ? IDLE : REQ;
            end else begin
              skid_n  = {imem_rdata, pc};
              state_n = FULL;
            end
          end
        end
        FULL: begin
          if (consumed) begin
            out_n   = skid;
            vld_n   = 1'b1;
            skid_n  = '0;
            state_n = IDLE;
          end
        end
        DROP: if (imem_ready) state_n = REQ;
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed vector bench for fetch_unit: table of per-cycle stimulus and
// expected post-edge outputs, plus hand sequences for async reset and wrap.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk, rst;
  logic        imem_req, imem_ready, stall, branch_taken, instr_valid;
  logic [31:0] imem_addr, imem_rdata, branch_target, instr, pc_out;
  logic [6:0]  op, funct7;
  logic [2:0]  funct3;

  int n_chk = 0;
  int n_err = 0;

  fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .instr_valid(instr_valid), .instr(instr), .pc_out(pc_out),
    .Op(op), .funct3(funct3), .funct7(funct7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, rdy, stl, br;
    logic [31:0] rd, tgt;
    logic        ereq;
    logic [31:0] eaddr;
    logic        evld;
    logic [31:0] einstr, epc;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic r, rdy, stl, br,
                              input logic [31:0] rd, tgt,
                              input logic ereq, input logic [31:0] eaddr,
                              input logic evld, input logic [31:0] einstr, epc);
    vec_t v;
    v.rst = r; v.rdy = rdy; v.stl = stl; v.br = br; v.rd = rd; v.tgt = tgt;
    v.ereq = ereq; v.eaddr = eaddr; v.evld = evld; v.einstr = einstr; v.epc = epc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, rdy, stl, br, input logic [31:0] rd, tgt);
    rst = r; imem_ready = rdy; stall = stl; branch_taken = br;
    imem_rdata = rd; branch_target = tgt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic ereq, input logic [31:0] eaddr,
                         input logic evld, input logic [31:0] einstr, epc);
    logic [31:0] ei;
    ei = einstr;
    chk({tag, ".req"},   {31'd0, imem_req},    {31'd0, ereq});
    chk({tag, ".addr"},  imem_addr,            eaddr);
    chk({tag, ".vld"},   {31'd0, instr_valid}, {31'd0, evld});
    chk({tag, ".instr"}, instr,                ei);
    chk({tag, ".pc"},    pc_out,               epc);
    chk({tag, ".op"},    {25'd0, op},          {25'd0, ei[6:0]});
    chk({tag, ".f3"},    {29'd0, funct3},      {29'd0, ei[14:12]});
    chk({tag, ".f7"},    {25'd0, funct7},      {25'd0, ei[31:25]});
  endtask

  initial begin
    // stream 1: zero-wait fetch, then 3-cycle wait at 0x8
    tv.push_back(mk(0,1,0,0, 32'h0,   0, 1,32'h0,  0,NOP,  32'h0));
    tv.push_back(mk(0,1,0,0, 32'h0,   0, 1,32'h4,  1,32'h0,32'h0));
    tv.push_back(mk(0,1,0,0, 32'h4,   0, 1,32'h8,  1,32'h4,32'h4));
    tv.push_back(mk(0,0,0,0, 32'h0,   0, 1,32'h8,  0,NOP,  32'h4));
    tv.push_back(mk(0,0,0,0, 32'h0,   0, 1,32'h8,  0,NOP,  32'h4));
    tv.push_back(mk(0,0,0,0, 32'h0,   0, 1,32'h8,  0,NOP,  32'h4));
    tv.push_back(mk(0,1,0,0, 32'h8,   0, 1,32'hC,  1,32'h8,32'h8));
    tv.push_back(mk(0,1,0,0, 32'hC,   0, 1,32'h10, 1,32'hC,32'hC));
    // synchronous-looking reset vector, then skid scenario at 0x4/0x8
    tv.push_back(mk(1,1,0,0, 32'h10,  0, 0,32'h0,  0,NOP,  32'h0));
    tv.push_back(mk(0,1,0,0, 32'h0,   0, 1,32'h0,  0,NOP,  32'h0));
    tv.push_back(mk(0,1,0,0, 32'h0,   0, 1,32'h4,  1,32'h0,32'h0));
    tv.push_back(mk(0,1,0,0, 32'h4,   0, 1,32'h8,  1,32'h4,32'h4));
    tv.push_back(mk(0,1,1,0, 32'h8,   0, 0,32'hC,  1,32'h4,32'h4));
    tv.push_back(mk(0,1,1,0, 32'hEE,  0, 0,32'hC,  1,32'h4,32'h4));
    tv.push_back(mk(0,1,1,0, 32'hEE,  0, 0,32'hC,  1,32'h4,32'h4));
    tv.push_back(mk(0,1,1,0, 32'hEE,  0, 0,32'hC,  1,32'h4,32'h4));
    tv.push_back(mk(0,1,0,0, 32'hEE,  0, 0,32'hC,  1,32'h8,32'h8));
    tv.push_back(mk(0,1,0,0, 32'hEE,  0, 1,32'hC,  0,NOP,  32'h8));
    tv.push_back(mk(0,1,0,0, 32'hC,   0, 1,32'h10, 1,32'hC,32'hC));
    // branch to 0x100 during a wait at 0x10
    tv.push_back(mk(0,0,0,0, 32'h0,   0,        1,32'h10,  0,NOP,    32'hC));
    tv.push_back(mk(0,0,0,1, 32'h0,   32'h100,  1,32'h10,  0,NOP,    32'hC));
    tv.push_back(mk(0,1,0,0, 32'hDEAD0010, 0,   1,32'h100, 0,NOP,    32'hC));
    tv.push_back(mk(0,1,0,0, 32'h100, 0,        1,32'h104, 1,32'h100,32'h100));
    // branch + stall + ready in one cycle
    tv.push_back(mk(0,1,1,1, 32'h104, 32'h0,    1,32'h0,   0,NOP,    32'h100));
    tv.push_back(mk(0,1,0,0, 32'h0,   0,        1,32'h4,   1,32'h0,  32'h0));
    // misaligned target, decode-field instruction
    tv.push_back(mk(0,0,0,1, 32'h0,   32'h203,  1,32'h4,   0,NOP,    32'h0));
    tv.push_back(mk(0,1,0,0, 32'hBAD, 0,        1,32'h200, 0,NOP,    32'h0));
    tv.push_back(mk(0,1,0,0, 32'h4000_5033, 0,  1,32'h204, 1,32'h4000_5033, 32'h200));

    drive(1, 0, 0, 0, 0, 0);
    tick();
    chk_out("reset", 0, 32'h0, 0, NOP, 32'h0);

    foreach (tv[i]) begin
      drive(tv[i].rst, tv[i].rdy, tv[i].stl, tv[i].br, tv[i].rd, tv[i].tgt);
      tick();
      chk_out($sformatf("v%0d", i), tv[i].ereq, tv[i].eaddr, tv[i].evld, tv[i].einstr, tv[i].epc);
    end

    chk("decode.op", {25'd0, op},     32'h33);
    chk("decode.f3", {29'd0, funct3}, 32'h5);
    chk("decode.f7", {25'd0, funct7}, 32'h20);

    // async reset mid-wait at 0x20 with a valid instruction held
    drive(0, 1, 0, 1, 32'h0, 32'h1C);
    tick();
    chk_out("br1c", 1, 32'h1C, 0, NOP, 32'h200);
    drive(0, 1, 0, 0, 32'h1C, 0);
    tick();
    chk_out("ld1c", 1, 32'h20, 1, 32'h1C, 32'h1C);
    drive(0, 0, 1, 0, 32'h0, 0);
    tick();
    chk_out("wait20", 1, 32'h20, 1, 32'h1C, 32'h1C);
    #2;
    drive(1, 1, 0, 0, 32'h20, 0);
    #1;
    chk_out("arst", 0, 32'h0, 0, NOP, 32'h0);
    tick();
    chk_out("arst_hold", 0, 32'h0, 0, NOP, 32'h0);
    drive(0, 1, 0, 0, 32'h0, 0);
    tick();
    chk_out("restart", 1, 32'h0, 0, NOP, 32'h0);

    // PC wrap at the top of the address space
    drive(0, 1, 0, 1, 32'h0, 32'hFFFF_FFFC);
    tick();
    chk_out("brtop", 1, 32'hFFFF_FFFC, 0, NOP, 32'h0);
    drive(0, 1, 0, 0, 32'h0000_0013, 0);
    tick();
    chk_out("wrap", 1, 32'h0, 1, 32'h0000_0013, 32'hFFFF_FFFC);
    drive(0, 1, 0, 0, 32'h0000_0093, 0);
    tick();
    chk_out("post_wrap", 1, 32'h4, 1, 32'h0000_0093, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
